// File: rtl/jts16_load_pkg.sv
// rtl/jts16_load_pkg.sv - shared types and constants for the S16 download loader
// State encoding, checksum width and a constant clog2 helper.
package jts16_load_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EVAL = 2'd2,
      ST_DONE = 2'd3
   } ld_state_e;

   localparam int CHKW = 16;

   function automatic int clog2(input longint unsigned v);
      int r;
      r = 0;
      while ((64'd1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/jts16_load_region.sv
// rtl/jts16_load_region.sv - one PROM/key window: match, offset, fill counter, done flag
// Optional byte checksum when JTS16_LDCHK_EN is defined.
module jts16_load_region
   import jts16_load_pkg::*;
#(
   parameter int            AW    = 25,
   parameter int            CW    = 9,
   parameter logic [AW-1:0] START = '0,
   parameter logic [AW-1:0] LEN   = AW'(256)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr_i,
   input  logic            we_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [7:0]      data_i,
   output logic            match_o,
   output logic [AW-1:0]   offset_o,
   output logic            full_o,
   output logic            done_o,
   output logic [CHKW-1:0] chk_o
);

   localparam logic [CW-1:0] LEN_C = CW'(LEN);

   // Extra borrow bit folds the lower-bound compare into the subtraction.
   logic [AW:0]   diff;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;

   assign diff     = {1'b0, addr_i} - {1'b0, START};
   assign match_o  = !diff[AW] && (diff[AW-1:0] < LEN);
   assign offset_o = diff[AW-1:0];
   assign full_o   = (cnt_q == LEN_C);
   assign done_o   = done_q;

   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q | full_o;
      if (we_i && !full_o) cnt_d = cnt_q + CW'(1);
      if (clr_i) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

`ifdef JTS16_LDCHK_EN
   logic [CHKW-1:0] chk_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clr_i) chk_q <= '0;
      else if (we_i)       chk_q <= chk_q + CHKW'(data_i);
   end

   assign chk_o = chk_q;
`else
   logic unused_data;

   assign unused_data = ^data_i;
   assign chk_o       = '0;
`endif

endmodule

// File: rtl/jts16_load_cfg.sv
// rtl/jts16_load_cfg.sv - download snooper: header bank capture and PROM/key window routing
// Define JTS16_LDCHK_EN to enable per-region byte checksums on reg_chk.
module jts16_load_cfg
   import jts16_load_pkg::*;
#(
   parameter int                    AW        = 25,
   parameter int                    REGIONS   = 4,
   parameter int                    HDR_BYTES = 16,
   parameter logic [REGIONS*AW-1:0] REG_START = {REGIONS{AW'(0)}},
   parameter logic [REGIONS*AW-1:0] REG_LEN   = {REGIONS{AW'(256)}}
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      downloading,
   input  logic                      header,
   input  logic                      prog_we,
   input  logic [AW-1:0]             prog_addr,
   input  logic [7:0]                prog_data,
   output logic [HDR_BYTES*8-1:0]    hdr_cfg,
   output logic [REGIONS-1:0]        reg_we,
   output logic [AW-1:0]             reg_addr,
   output logic [7:0]                reg_data,
   output logic [REGIONS-1:0]        reg_done,
   output logic [REGIONS-1:0]        reg_short,
   output logic                      load_done,
   output logic [REGIONS*CHKW-1:0]   reg_chk
);

   function automatic int max_len();
      int m = 1;
      for (int i = 0; i < REGIONS; i++)
         if (int'(REG_LEN[i*AW+:AW]) > m) m = int'(REG_LEN[i*AW+:AW]);
      return m;
   endfunction

   localparam int CW = clog2(max_len()) + 1;
   localparam int HB = clog2(HDR_BYTES);

   ld_state_e              state_q, state_d;
   logic                   dl_q, rise, load_start, accept, body_we, hdr_we, hit;
   logic [HB-1:0]          hdr_idx;
   logic [HDR_BYTES*8-1:0] hdr_q;
   logic [REGIONS-1:0]     we_q, short_q, match, full, sel;
   logic [AW-1:0]          addr_q, sel_off;
   logic [7:0]             data_q;
   logic                   ldone_q;
   logic [AW-1:0]          off [REGIONS];

   assign rise    = downloading && !dl_q;
   assign accept  = (state_q == ST_LOAD);
   assign body_we = accept && prog_we && !header;
   assign hdr_we  = accept && prog_we && header && ((prog_addr >> HB) == '0);
   assign hdr_idx = prog_addr[HB-1:0];

   always_comb begin
      state_d    = state_q;
      load_start = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: if (rise) begin
            state_d    = ST_LOAD;
            load_start = 1'b1;
         end
         ST_LOAD: if (!downloading) state_d = ST_EVAL;
         ST_EVAL: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Walk from the top so the lowest matching region wins.
   always_comb begin
      sel     = '0;
      sel_off = '0;
      hit     = 1'b0;
      for (int i = REGIONS-1; i >= 0; i--) begin
         if (match[i]) begin
            sel     = '0;
            sel[i]  = 1'b1;
            sel_off = off[i];
            hit     = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < REGIONS; g++) begin : g_region
      jts16_load_region #(
         .AW    (AW),
         .CW    (CW),
         .START (REG_START[g*AW+:AW]),
         .LEN   (REG_LEN[g*AW+:AW])
      ) u_region (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr_i    (load_start),
         .we_i     (body_we && sel[g]),
         .addr_i   (prog_addr),
         .data_i   (prog_data),
         .match_o  (match[g]),
         .offset_o (off[g]),
         .full_o   (full[g]),
         .done_o   (reg_done[g]),
         .chk_o    (reg_chk[g*CHKW+:CHKW])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dl_q    <= downloading;
         hdr_q   <= '0;
         we_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         short_q <= '0;
         ldone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dl_q    <= downloading;
         we_q    <= body_we ? sel : '0;
         if (body_we && hit) begin
            addr_q <= sel_off;
            data_q <= prog_data;
         end
         if (load_start) begin
            hdr_q   <= '0;
            short_q <= '0;
            ldone_q <= 1'b0;
         end else begin
            if (hdr_we) hdr_q[hdr_idx*8 +: 8] <= prog_data;
            // full covers a region completed by a write in the falling cycle.
            if (state_q == ST_EVAL) begin
               short_q <= ~(reg_done | full);
               ldone_q <= 1'b1;
            end
         end
      end
   end

   assign hdr_cfg   = hdr_q;
   assign reg_we    = we_q;
   assign reg_addr  = addr_q;
   assign reg_data  = data_q;
   assign reg_short = short_q;
   assign load_done = ldone_q;

endmodule

// File: tb/tb_jts16_load_cfg.sv
// tb/tb_jts16_load_cfg.sv - randomized self-checking bench for jts16_load_cfg
// Reference model tracks the download as phases, byte counts and sums.
module tb_jts16_load_cfg;

   localparam int AW = 25;
   localparam int NR = 4;
   localparam int HB = 16;
   localparam logic [NR*AW-1:0] STARTS = {25'h5000, 25'h0080, 25'h2000, 25'h0000};
   localparam logic [NR*AW-1:0] LENS   = {25'd4,    25'h100,  25'h2000, 25'h100};

   logic            clk = 1'b0;
   logic            rst_n, downloading, header, prog_we;
   logic [AW-1:0]   prog_addr;
   logic [7:0]      prog_data;
   logic [HB*8-1:0] hdr_cfg;
   logic [NR-1:0]   reg_we, reg_done, reg_short;
   logic [AW-1:0]   reg_addr;
   logic [7:0]      reg_data;
   logic            load_done;
   logic [NR*16-1:0] reg_chk;

   jts16_load_cfg #(
      .AW(AW), .REGIONS(NR), .HDR_BYTES(HB), .REG_START(STARTS), .REG_LEN(LENS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .downloading(downloading), .header(header),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .hdr_cfg(hdr_cfg), .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
      .reg_done(reg_done), .reg_short(reg_short), .load_done(load_done), .reg_chk(reg_chk)
   );

   always #5 clk = ~clk;

   int unsigned st [NR] = '{32'h0, 32'h2000, 32'h80, 32'h5000};
   int unsigned ln [NR] = '{32'h100, 32'h2000, 32'h100, 32'd4};

   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_phase;          // 0 idle, 1 loading, 2 evaluating, 3 finished
   bit          m_prev_dl;
   int unsigned m_cnt [NR];
   bit [15:0]   m_chk [NR];
   bit [7:0]    m_hdr [HB];
   bit [NR-1:0] m_done, m_short, m_we;
   bit          m_ldone;
   bit [AW-1:0] m_addr;
   bit [7:0]    m_data;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NR; i++) begin
         m_cnt[i] = 0;
         m_chk[i] = 0;
      end
      for (int k = 0; k < HB; k++) m_hdr[k] = 0;
      m_done  = 0;
      m_short = 0;
      m_ldone = 0;
   endtask

   task automatic compare_all();
      logic [HB*8-1:0]  eh;
      logic [NR*16-1:0] ec;
      for (int k = 0; k < HB; k++) eh[k*8+:8] = m_hdr[k];
      for (int i = 0; i < NR; i++) begin
`ifdef JTS16_LDCHK_EN
         ec[i*16+:16] = m_chk[i];
`else
         ec[i*16+:16] = 16'h0;
`endif
      end
      check("reg_we",    reg_we,    m_we);
      check("reg_addr",  reg_addr,  m_addr);
      check("reg_data",  reg_data,  m_data);
      check("reg_done",  reg_done,  m_done);
      check("reg_short", reg_short, m_short);
      check("load_done", load_done, m_ldone);
      check("hdr_cfg",   hdr_cfg,   eh);
      check("reg_chk",   reg_chk,   ec);
   endtask

   task automatic step(input bit rn, input bit dl, input bit hd, input bit we,
                       input int unsigned a, input bit [7:0] d);
      bit rise;
      int hit;
      rst_n = rn; downloading = dl; header = hd; prog_we = we;
      prog_addr = a[AW-1:0]; prog_data = d;
      if (!rn) begin
         clear_model();
         m_we = 0; m_addr = 0; m_data = 0; m_phase = 0;
      end else begin
         rise = dl && !m_prev_dl;
         m_we = 0;
         for (int i = 0; i < NR; i++) if (m_cnt[i] >= ln[i]) m_done[i] = 1'b1;
         if (m_phase == 1 && we) begin
            if (hd) begin
               if (a < HB) m_hdr[a] = d;
            end else begin
               hit = -1;
               for (int i = 0; i < NR; i++)
                  if (hit < 0 && a >= st[i] && a < st[i] + ln[i]) hit = i;
               if (hit >= 0) begin
                  m_we[hit] = 1'b1;
                  m_addr    = AW'(a - st[hit]);
                  m_data    = d;
                  if (m_cnt[hit] < ln[hit]) m_cnt[hit]++;
                  m_chk[hit] = m_chk[hit] + 16'(d);
               end
            end
         end
         case (m_phase)
            0, 3: if (rise) begin clear_model(); m_phase = 1; end
            1: if (!dl) m_phase = 2;
            default: begin
               for (int i = 0; i < NR; i++) m_short[i] = (m_cnt[i] < ln[i]);
               m_ldone = 1'b1;
               m_phase = 3;
            end
         endcase
      end
      m_prev_dl = dl;
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      int unsigned a;
      bit          hd;
      bit [7:0]    d;
      rst_n = 0; downloading = 0; header = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check("rst_we", reg_we, 4'b0000);
      check("rst_ldone", load_done, 1'b0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);

      step(1, 1, 1, 1, 0, 8'h06);
      step(1, 1, 1, 1, 1, 8'h02);
      step(1, 1, 1, 1, HB, 8'hAA);
      check("hdr_first", hdr_cfg[15:0], 16'h0206);

      step(1, 1, 0, 1, 32'h2003, 8'h5A);
      check("route_we", reg_we, 4'b0010);
      check("route_addr", reg_addr, 25'd3);
      check("route_data", reg_data, 8'h5A);
      step(1, 1, 0, 1, 32'h4000, 8'h33);
      check("nomatch_we", reg_we, 4'b0000);

      for (int k = 0; k < 256; k++) step(1, 1, 0, 1, k, 8'($urandom()));
      check("done0_lag", reg_done[0], 1'b0);
      step(1, 1, 0, 0, 0, 0);
      check("done0_set", reg_done[0], 1'b1);

      step(1, 1, 0, 1, 32'h00C0, 8'h11);
      check("overlap_we", reg_we, 4'b0001);

      for (int k = 0; k < 200; k++) begin
         hd = 1'b0;
         case ($urandom_range(0, 3))
            0: a = $urandom_range(0, 32'h17F);
            1: a = 32'h1FF0 + $urandom_range(0, 32'h2020);
            2: a = 32'h5000 + $urandom_range(0, 7);
            default: begin a = $urandom_range(0, 31); hd = 1'b1; end
         endcase
         d = 8'($urandom());
         step(1, 1, hd, 1'($urandom_range(0, 1)), a, d);
      end

      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("eval_ldone", load_done, 1'b1);
      check("eval_short0", reg_short[0], 1'b0);
      check("eval_short2", reg_short[2], 1'b1);

      step(1, 1, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) step(1, 1, 0, 1, 32'h2100 + k, 8'($urandom()));
      step(0, 1, 0, 1, 32'h2200, 8'h44);
      check("rst_mid_done", reg_done, 4'b0000);
      check("rst_mid_hdr", hdr_cfg, '0);
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 0, 1, 32'h2000 + k, 8'($urandom()));
         check("ignored_we", reg_we, 4'b0000);
      end

      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0, 8'hFF);
      step(1, 1, 0, 1, 1, 8'h02);
`ifdef JTS16_LDCHK_EN
      check("chk_sum", reg_chk[15:0], 16'h0101);
`else
      check("chk_off", reg_chk, '0);
`endif
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("final_ldone", load_done, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
